fetch_stage_bpred: RTL and testbench
====================================

// Module: fetch_stage_bpred
// PURPOSE
// - Instruction-fetch stage of the RV32I pipeline, directly upstream of the IF/ID register.
// - Owns the PC register, drives the instruction-memory address and produces pc, pc+4,
//   instruction and the branch-prediction bit consumed by IF/ID.
// - Dynamic prediction: 2-bit-counter BHT plus direct-mapped BTB, trained and redirected from EX.
// PARAMETERS
// - RESET_PC     32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
// - BHT_ENTRIES  64             2-bit counters, power of 2, indexed by pc[log2(BHT_ENTRIES)+1:2]
// - BTB_ENTRIES  16             direct-mapped targets, power of 2, indexed by pc[log2(BTB_ENTRIES)+1:2]
// PORTS
// - clk             in   1   rising-edge clock
// - rst             in   1   synchronous reset, active-low (rst==0 resets on the clk edge)
// - stall           in   1   hold PC, no fetch advance (hazard unit)
// - ex_redirect     in   1   mispredict or jump resolved in EX; load ex_redirect_pc
// - ex_redirect_pc  in   32  correct next PC from EX
// - ex_update       in   1   conditional branch resolved in EX this cycle; train predictor
// - ex_pc           in   32  PC of the resolved branch
// - ex_taken        in   1   actual branch outcome
// - ex_target       in   32  actual branch target
// - imem_addr       out  32  instruction-memory address (= PC), combinational read
// - imem_rdata      in   32  instruction word at imem_addr, same cycle
// - pc_out          out  32  current PC -> IF/ID pc_in
// - pc4_out         out  32  PC+4 -> IF/ID pc4_in
// - instruction_out out  32  imem_rdata passed through -> IF/ID instruction_in
// - prediction_out  out  1   1 = predicted taken -> IF/ID prediction_in
// BEHAVIOUR
// - State: PC (32b), BHT counters, BTB {valid, tag = pc[31:idx_msb+1], target[31:2]}.
// - Reset (rst==0 at posedge): PC <= RESET_PC; all BHT counters <= 2'b01 (weak not-taken);
//   all BTB valid <= 0. Reset wins over every other input, including mid-redirect or mid-update.
// - After reset: pc_out=RESET_PC, pc4_out=RESET_PC+4, prediction_out=0.
// - Outputs are combinational from the PC register: zero added latency; imem_addr=pc_out.
// - Lookup: hit = btb_valid & tag match; prediction_out = hit & bht[idx][1].
//   next_pred = prediction_out ? {btb_target,2'b00} : pc+4.
// - PC update priority per posedge: rst==0 > ex_redirect > stall > next_pred.
//   ex_redirect overrides stall (wrong-path fetch must not be held).
// - Redirect PC bits [1:0] are forced to 2'b00.
// - pc+4 is modulo 2^32: PC 32'hFFFF_FFFC -> 32'h0000_0000, no flag.
// - Training on ex_update: counter at ex_pc index saturating +1 if ex_taken, -1 if not
//   (3 stays 3, 0 stays 0). If ex_taken: BTB entry at ex_pc index <= {1, tag(ex_pc), ex_target[31:2]}.
//   Not-taken never writes or invalidates the BTB.
// - ex_update is independent of stall; training happens even while stalled.
// - Same-cycle lookup and update to one index: lookup sees the pre-update value (no bypass).
// - ex_redirect without ex_update (e.g. JALR) changes PC only, no training.
// CONFIGURATION
// - Macro FETCH_BPRED_EN.
//   Defined: BHT/BTB built, behaviour as above.
//   Undefined: no BHT/BTB storage; prediction_out tied 0; next_pred = pc+4; ex_update,
//   ex_pc, ex_taken, ex_target ignored. Redirect/stall/reset behaviour unchanged.
// STRUCTURE
// - Shared package/header: XLEN=32, RESET_PC default, 2-bit counter encodings
//   (SNT=00, WNT=01, WT=10, ST=11).
// - One sub-module: bpred_bht_btb (lookup port on PC, update port from EX, synchronous
//   reset of counters/valids). Top holds PC register, next-PC mux and output wiring.
// TESTING
// - Reset: rst=0 one edge, then rst=1 -> pc_out=0, pc4_out=4, prediction_out=0; 3 edges -> PC 4,8,12.
// - Stall: stall=1 at PC=0x10 for 3 edges -> pc_out stays 0x10; release -> 0x14.
// - Redirect vs stall: stall=1, ex_redirect=1, ex_redirect_pc=0x203 -> next pc_out=0x200.
// - Training: ex_update, ex_taken=1, ex_pc=0x40, ex_target=0x100 twice; fetch 0x40 ->
//   prediction_out=1, next PC 0x100. Two not-taken updates -> prediction_out=0, next PC 0x44.
// - Saturation/no-bypass: 5 taken updates then 1 not-taken -> still predicts taken; lookup
//   of 0x40 in the same cycle as its first update -> prediction_out=0.
// - Wrap and reset mid-op: PC=0xFFFF_FFFC -> next 0x0; rst=0 together with ex_redirect ->
//   PC=RESET_PC, BTB cleared. Re-run with FETCH_BPRED_EN undefined -> prediction_out always 0.

Source files
------------

// File: rtl/fetch_stage_bpred_pkg.sv
// ============================================================================
// Module : fetch_stage_bpred_pkg
// Brief  : Shared constants and 2-bit counter helper for the fetch stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fetch_stage_bpred_pkg;

    localparam int               XLEN             = 32;
    localparam logic [XLEN-1:0]  RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
        if (taken) begin
            return (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
        end
        return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_stage_bpred_if.sv
// ============================================================================
// Module : fetch_stage_bpred_if
// Brief  : Hazard/EX control, instruction memory and IF/ID signals of fetch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fetch_stage_bpred_if;
    import fetch_stage_bpred_pkg::*;

    logic            stall;
    logic            ex_redirect;
    logic [XLEN-1:0] ex_redirect_pc;
    logic            ex_update;
    logic [XLEN-1:0] ex_pc;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] pc4_out;
    logic [XLEN-1:0] instruction_out;
    logic            prediction_out;

    modport master (
        output stall, ex_redirect, ex_redirect_pc, ex_update, ex_pc, ex_taken,
               ex_target, imem_rdata,
        input  imem_addr, pc_out, pc4_out, instruction_out, prediction_out
    );

    modport slave (
        input  stall, ex_redirect, ex_redirect_pc, ex_update, ex_pc, ex_taken,
               ex_target, imem_rdata,
        output imem_addr, pc_out, pc4_out, instruction_out, prediction_out
    );

endinterface

`default_nettype wire

// File: rtl/fetch_stage_bpred_bht_btb.sv
// ============================================================================
// Module : fetch_stage_bpred_bht_btb
// Brief  : 2-bit-counter BHT plus direct-mapped BTB; lookup on PC, train from EX.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage_bpred_bht_btb
    import fetch_stage_bpred_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int BTB_ENTRIES = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic [XLEN-1:2] lookup_pc_i,
    output logic                 predict_o,
    output logic [XLEN-1:0]      target_o,
    input  wire logic            upd_en_i,
    input  wire logic [XLEN-1:2] upd_pc_i,
    input  wire logic            upd_taken_i,
    input  wire logic [XLEN-1:2] upd_target_i
);

    localparam int BHT_IW  = $clog2(BHT_ENTRIES);
    localparam int BTB_IW  = $clog2(BTB_ENTRIES);
    localparam int TAG_LSB = BTB_IW + 2;

    logic [1:0]            bht_q       [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [XLEN-1:TAG_LSB] btb_tag_q   [BTB_ENTRIES];
    logic [XLEN-1:2]       btb_tgt_q   [BTB_ENTRIES];

    logic [BHT_IW-1:0] w_lk_bht_idx;
    logic [BTB_IW-1:0] w_lk_btb_idx;
    logic [BHT_IW-1:0] w_up_bht_idx;
    logic [BTB_IW-1:0] w_up_btb_idx;
    logic              w_hit;

    assign w_lk_bht_idx = lookup_pc_i[BHT_IW+1:2];
    assign w_lk_btb_idx = lookup_pc_i[BTB_IW+1:2];
    assign w_up_bht_idx = upd_pc_i[BHT_IW+1:2];
    assign w_up_btb_idx = upd_pc_i[BTB_IW+1:2];

    // Lookup reads the registered arrays, so a same-cycle update is not visible.
    assign w_hit     = btb_valid_q[w_lk_btb_idx] &&
                       (btb_tag_q[w_lk_btb_idx] == lookup_pc_i[XLEN-1:TAG_LSB]);
    assign predict_o = w_hit & bht_q[w_lk_bht_idx][1];
    assign target_o  = {btb_tgt_q[w_lk_btb_idx], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_WNT;
            end
        end else if (upd_en_i) begin
            bht_q[w_up_bht_idx] <= ctr_next(bht_q[w_up_bht_idx], upd_taken_i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_valid_q <= '0;
        end else if (upd_en_i && upd_taken_i) begin
            btb_valid_q[w_up_btb_idx] <= 1'b1;
        end
    end

    // Tag/target payload needs no reset: it is only observed through a valid bit.
    always_ff @(posedge clk) begin
        if (rst && upd_en_i && upd_taken_i) begin
            btb_tag_q[w_up_btb_idx] <= upd_pc_i[XLEN-1:TAG_LSB];
            btb_tgt_q[w_up_btb_idx] <= upd_target_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_stage_bpred.sv
// ============================================================================
// Module : fetch_stage_bpred
// Brief  : RV32I fetch stage: PC register, next-PC mux, optional dynamic
//          predictor enabled by macro FETCH_BPRED_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fetch_stage_bpred
    import fetch_stage_bpred_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int              BHT_ENTRIES = 64,
    parameter int              BTB_ENTRIES = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    fetch_stage_bpred_if.slave  bus
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] w_pc4;
    logic            w_pred;
    logic [XLEN-1:0] w_pred_tgt;

    assign w_pc4 = pc_q + 32'd4;

`ifdef FETCH_BPRED_EN
    fetch_stage_bpred_bht_btb #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_bht_btb (
        .clk          (clk),
        .rst          (rst),
        .lookup_pc_i  (pc_q[XLEN-1:2]),
        .predict_o    (w_pred),
        .target_o     (w_pred_tgt),
        .upd_en_i     (bus.ex_update),
        .upd_pc_i     (bus.ex_pc[XLEN-1:2]),
        .upd_taken_i  (bus.ex_taken),
        .upd_target_i (bus.ex_target[XLEN-1:2])
    );
`else
    assign w_pred     = 1'b0;
    assign w_pred_tgt = w_pc4;
`endif

    // A redirect beats stall so a wrong-path fetch is never held.
    always_comb begin
        pc_d = w_pred ? w_pred_tgt : w_pc4;
        if (bus.stall) begin
            pc_d = pc_q;
        end
        if (bus.ex_redirect) begin
            pc_d = {bus.ex_redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.imem_addr       = pc_q;
    assign bus.pc_out          = pc_q;
    assign bus.pc4_out         = w_pc4;
    assign bus.instruction_out = bus.imem_rdata;
    assign bus.prediction_out  = w_pred;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_bpred.sv
// ============================================================================
// Module : tb_fetch_stage_bpred
// Brief  : Scoreboard bench for fetch_stage_bpred against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fetch_stage_bpred;
    import fetch_stage_bpred_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int NBHT = 64;
    localparam int NBTB = 16;
    localparam int TSH  = $clog2(NBTB) + 2;
`ifdef FETCH_BPRED_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_bpred_if bus();

    fetch_stage_bpred #(
        .RESET_PC    (RST_PC),
        .BHT_ENTRIES (NBHT),
        .BTB_ENTRIES (NBTB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        pred;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference state: plain arrays, counters as small integers 0..3.
    logic [31:0] m_pc;
    int          m_bht [NBHT];
    bit          m_bv  [NBTB];
    logic [31:0] m_tag [NBTB];
    logic [31:0] m_tgt [NBTB];

    function automatic bit m_predict();
        int bi = int'((m_pc >> 2) % NBHT);
        int ti = int'((m_pc >> 2) % NBTB);
        return PRED_EN && m_bv[ti] && (m_tag[ti] == (m_pc >> TSH)) && (m_bht[bi] >= 2);
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        foreach (m_bht[i]) m_bht[i] = 1;
        foreach (m_bv[i])  m_bv[i]  = 1'b0;
    endtask

    task automatic model_edge(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                              input bit up, input logic [31:0] epc, input bit tk,
                              input logic [31:0] tg);
        bit p;
        int bi;
        int ti;
        if (!r) begin
            model_reset();
            return;
        end
        p = m_predict();
        if (rd)
            m_pc = rpc & ~32'h3;
        else if (!s)
            m_pc = p ? m_tgt[int'((m_pc >> 2) % NBTB)] : m_pc + 32'd4;
        if (up && PRED_EN) begin
            bi = int'((epc >> 2) % NBHT);
            m_bht[bi] = tk ? ((m_bht[bi] == 3) ? 3 : m_bht[bi] + 1)
                           : ((m_bht[bi] == 0) ? 0 : m_bht[bi] - 1);
            if (tk) begin
                ti = int'((epc >> 2) % NBTB);
                m_bv[ti]  = 1'b1;
                m_tag[ti] = epc >> TSH;
                m_tgt[ti] = tg & ~32'h3;
            end
        end
    endtask

    task automatic apply(input bit r, input bit s, input bit rd, input logic [31:0] rpc,
                         input bit up, input logic [31:0] epc, input bit tk,
                         input logic [31:0] tg);
        exp_t e;
        rst                = r;
        bus.stall          = s;
        bus.ex_redirect    = rd;
        bus.ex_redirect_pc = rpc;
        bus.ex_update      = up;
        bus.ex_pc          = epc;
        bus.ex_taken       = tk;
        bus.ex_target      = tg;
        bus.imem_rdata     = $urandom();
        e.pc    = m_pc;
        e.pc4   = m_pc + 32'd4;
        e.instr = bus.imem_rdata;
        e.pred  = m_predict();
        sb.push_back(e);
        @(posedge clk);
        model_edge(r, s, rd, rpc, up, epc, tk, tg);
        #1;
    endtask

    task automatic idle();
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic redirect(input logic [31:0] a);
        apply(1'b1, 1'b0, 1'b1, a, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input logic [31:0] epc, input bit tk, input logic [31:0] tg);
        apply(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, epc, tk, tg);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("pc_out",          bus.pc_out,          e.pc);
                check("imem_addr",       bus.imem_addr,       e.pc);
                check("pc4_out",         bus.pc4_out,         e.pc4);
                check("instruction_out", bus.instruction_out, e.instr);
                check("prediction_out",  {31'd0, bus.prediction_out}, {31'd0, e.pred});
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst                = 1'b0;
        bus.stall          = 1'b0;
        bus.ex_redirect    = 1'b0;
        bus.ex_redirect_pc = '0;
        bus.ex_update      = 1'b0;
        bus.ex_pc          = '0;
        bus.ex_taken       = 1'b0;
        bus.ex_target      = '0;
        bus.imem_rdata     = '0;
        @(posedge clk);
        model_reset();
        #1;

        // Reset state then sequential fetch to 0x10, stall there, release.
        repeat (4) idle();
        repeat (3) apply(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        // Redirect beats stall, low bits dropped.
        apply(1'b1, 1'b1, 1'b1, 32'h203, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();

        // Training at 0x40 toward 0x100, then untraining.
        repeat (2) train(32'h40, 1'b1, 32'h100);
        redirect(32'h40);
        repeat (2) idle();
        repeat (2) train(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        repeat (2) idle();

        // Saturation: 5 taken then 1 not-taken still predicts taken.
        repeat (5) train(32'h40, 1'b1, 32'h100);
        train(32'h40, 1'b0, 32'h0);
        redirect(32'h40);
        repeat (2) idle();

        // No bypass: fresh reset, lookup of 0x40 during its first update.
        apply(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        redirect(32'h40);
        train(32'h40, 1'b1, 32'h100);
        idle();

        // PC wrap.
        redirect(32'hFFFF_FFFC);
        repeat (2) idle();

        // Reset together with redirect and update; BTB must be empty afterwards.
        repeat (2) train(32'h40, 1'b1, 32'h100);
        apply(1'b0, 1'b0, 1'b1, 32'h300, 1'b1, 32'h40, 1'b1, 32'h100);
        idle();
        redirect(32'h40);
        repeat (2) idle();

        // Randomized traffic concentrated on a small code region.
        for (int n = 0; n < 3000; n++) begin
            bit          r  = ($urandom_range(0, 199) != 0);
            bit          s  = ($urandom_range(0, 3) == 0);
            bit          rd = ($urandom_range(0, 7) == 0);
            logic [31:0] rpc = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            bit          up = ($urandom_range(0, 2) == 0);
            logic [31:0] epc = ($urandom_range(0, 1) == 0)
                               ? m_pc + ($urandom_range(0, 3) << 2)
                               : ($urandom_range(0, 127) << 2);
            bit          tk = ($urandom_range(0, 2) != 0);
            logic [31:0] tg = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            apply(r, s, rd, rpc, up, epc, tk, tg);
        end

        @(negedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
